pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised program-counter unit for the single-cycle RISC-V core; replaces the fixed 32-bit free-running PC.
- Generates the fetch address with a valid/ready handshake toward instruction memory.
- Supports stall, branch/jump redirect, trap vectoring, misaligned-target detection, halt/resume, and an accepted-fetch counter.
- Sits between the control/branch logic and the instruction-memory port.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect
PC_STEP, 4, sequential increment (4 = byte-addressed, 1 = word-addressed memory)
ALIGN_BITS, 2, low target bits that must be zero (0 disables the check; must be 0 when PC_STEP=1)
CNT_W, 32, fetch counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC (pipeline/memory hazard)
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  XLEN  new PC for redirect
trap_valid  in  1  exception/ecall: vector to TRAP_VECTOR
halt_req  in  1  request halt (ebreak/debug)
resume  in  1  leave HALT
fetch_ready  in  1  instruction memory accepts pc this cycle
pc  out  XLEN  current fetch address
pc_plus_step  out  XLEN  pc + PC_STEP, combinational (link value)
fetch_valid  out  1  pc is a valid fetch request
misaligned  out  1  one-cycle pulse: redirect target misaligned
misaligned_addr  out  XLEN  offending target, held until next misalignment
state  out  2  00 BOOT, 01 RUN, 10 HALT
fetch_count  out  CNT_W  number of accepted fetches

Behaviour:
- Reset (asynchronous, active-high; clock is clk):
  - pc=RESET_VECTOR, state=BOOT, fetch_valid=0, misaligned=0, misaligned_addr=0, fetch_count=0.
  - Reset asserted mid-operation aborts immediately; no pending update survives.
- BOOT: lasts exactly one clk edge after reset deasserts, then RUN. pc is not updated in BOOT.
- fetch_valid = (state==RUN) & ~stall, combinational.
- Fetch accepted when fetch_valid & fetch_ready. On acceptance, fetch_count increments and wraps modulo 2^CNT_W.
- Next-PC priority, evaluated each edge in RUN and HALT:
  1. trap_valid: pc ← TRAP_VECTOR.
  2. redirect_valid:
     - If target[ALIGN_BITS-1:0]≠0: pc ← TRAP_VECTOR, misaligned=1 for one cycle, misaligned_addr ← target.
     - Otherwise pc ← redirect_target.
  3. stall, or no fetch accepted: pc held.
  4. Fetch accepted: pc ← pc + PC_STEP, wrapping modulo 2^XLEN (all-ones-ish max → wraps to low addresses, no flag).
- Trap and redirect override stall; both are flushes.
- Redirect and fetch acceptance in the same cycle: the redirect wins. fetch_count still increments, because the fetch was accepted.
- Halt/resume:
  - halt_req in RUN → HALT at the next edge. The pc update from priority rules 1–4 still applies on that edge.
  - HALT: fetch_valid=0, so no acceptance and pc is held; trap/redirect still load pc.
  - resume in HALT → RUN at the next edge.
  - resume together with halt_req in HALT: stay HALT.
  - halt_req/resume in BOOT are ignored.
- misaligned is registered; it is never asserted in BOOT.
- pc_plus_step is combinational from pc; there is no extra latency.
- All state updates happen on the rising edge of clk only, apart from reset.

Decomposition:
- Shared package core_pkg:
  - state encodings: ST_BOOT=2'b00, ST_RUN=2'b01, ST_HALT=2'b10;
  - default XLEN and vector constants (RESET_VECTOR, TRAP_VECTOR).
- Sub-module pc_next_sel, combinational: priority mux and alignment check producing next_pc and misaligned_next.
- The top level holds the pc register, the FSM and fetch_count.

Test Plan:
- Reset release, fetch_ready=1, no other inputs:
  - cycle 0 BOOT, pc=0, fetch_valid=0;
  - then RUN with pc 0,4,8,C on successive edges;
  - fetch_count=4 after the 4th accepted fetch.
- stall=1 for 3 cycles at pc=8 → pc stays 8 and fetch_valid=0. Drop stall → pc=C next edge.
- At pc=10: redirect_valid=1, target=0x40, plus stall=1 → pc=0x40. Same cycle plus trap_valid=1 → pc=0x100 (trap wins).
- Redirect target 0x42 with ALIGN_BITS=2 → pc=0x100, misaligned pulses 1 cycle, misaligned_addr=0x42.
- Halt/resume:
  - halt_req at pc=0x20 → pc=0x24 at that edge, then state=HALT and pc stays 0x24 for 5 cycles with fetch_valid=0;
  - resume → RUN, pc=0x28 after the next accepted fetch.
- Wrap and async reset:
  - XLEN=8, PC_STEP=1: pc 0xFF → 0x00;
  - assert reset asynchronously mid-cycle → pc=RESET_VECTOR, state=BOOT immediately, before the next clk edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the fetch path: FSM state encoding and default
// address-map constants.
package core_pkg;

    localparam int          DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch request bus between the PC unit (master) and instruction memory (slave).
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc;
    logic            fetch_valid;
    logic            fetch_ready;

    modport master (
        output pc,
        output fetch_valid,
        input  fetch_ready
    );

    modport slave (
        input  pc,
        input  fetch_valid,
        output fetch_ready
    );
endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > redirect (with alignment check) > sequential step.
module pc_next_sel #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = '0,
    parameter int              ALIGN_BITS  = 2
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus_step_i,
    input  logic            trap_valid_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            fetch_accept_i,
    output logic [XLEN-1:0] pc_d_o,
    output logic            misaligned_d_o
);

    // ALIGN_BITS = 0 yields an empty mask, which disables the check.
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    logic target_misaligned;
    assign target_misaligned = |(redirect_target_i & ALIGN_MASK);

    always_comb begin
        pc_d_o         = pc_i;
        misaligned_d_o = 1'b0;
        if (trap_valid_i) begin
            pc_d_o = TRAP_VECTOR;
        end else if (redirect_valid_i) begin
            if (target_misaligned) begin
                pc_d_o         = TRAP_VECTOR;
                misaligned_d_o = 1'b1;
            end else begin
                pc_d_o = redirect_target_i;
            end
        end else if (fetch_accept_i) begin
            pc_d_o = pc_plus_step_i;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter unit: PC register, BOOT/RUN/HALT control and accepted-fetch
// counter, presenting the fetch address over a valid/ready interface.
module pc_fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int              PC_STEP      = 4,
    parameter int              ALIGN_BITS   = 2,
    parameter int              CNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    input  logic               trap_valid,
    input  logic               halt_req,
    input  logic               resume,
    pc_fetch_unit_if.master    fetch,
    output logic [XLEN-1:0]    pc_plus_step,
    output logic               misaligned,
    output logic [XLEN-1:0]    misaligned_addr,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   fetch_count
);

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic              misaligned_q;
    logic              misaligned_d;
    logic [XLEN-1:0]   misaligned_addr_q;
    logic [CNT_W-1:0]  fetch_count_q;
    logic              fetch_valid;
    logic              fetch_accept;

    assign fetch_valid  = (state_q == ST_RUN) && !stall;
    assign fetch_accept = fetch_valid && fetch.fetch_ready;
    assign pc_plus_step = pc_q + XLEN'(PC_STEP);

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .ALIGN_BITS  (ALIGN_BITS)
    ) u_next_sel (
        .pc_i              (pc_q),
        .pc_plus_step_i    (pc_plus_step),
        .trap_valid_i      (trap_valid),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .fetch_accept_i    (fetch_accept),
        .pc_d_o            (pc_d),
        .misaligned_d_o    (misaligned_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_BOOT;
            pc_q              <= RESET_VECTOR;
            misaligned_q      <= 1'b0;
            misaligned_addr_q <= '0;
            fetch_count_q     <= '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    // Control inputs are ignored for the single boot edge.
                    state_q      <= ST_RUN;
                    misaligned_q <= 1'b0;
                end
                ST_RUN, ST_HALT: begin
                    pc_q         <= pc_d;
                    misaligned_q <= misaligned_d;
                    if (misaligned_d) begin
                        misaligned_addr_q <= redirect_target;
                    end
                    if (fetch_accept) begin
                        fetch_count_q <= fetch_count_q + CNT_W'(1);
                    end
                    if (state_q == ST_RUN && halt_req) begin
                        state_q <= ST_HALT;
                    end else if (state_q == ST_HALT && resume && !halt_req) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    assign fetch.pc          = pc_q;
    assign fetch.fetch_valid = fetch_valid;
    assign misaligned        = misaligned_q;
    assign misaligned_addr   = misaligned_addr_q;
    assign state             = state_q;
    assign fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: expected fetch addresses are queued by the stimulus
// and checked by a monitor on every accepted fetch; control outputs are checked directly.
module tb_pc_fetch_unit;
    import core_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall, redirect_valid, trap_valid, halt_req, resume;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus_step, misaligned_addr, fetch_count;
    logic        misaligned;
    logic [1:0]  state;

    pc_fetch_unit_if #(.XLEN(32)) fif ();

    pc_fetch_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
        .PC_STEP(4), .ALIGN_BITS(2), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .halt_req(halt_req), .resume(resume),
        .fetch(fif), .pc_plus_step(pc_plus_step), .misaligned(misaligned),
        .misaligned_addr(misaligned_addr), .state(state), .fetch_count(fetch_count)
    );

    // Narrow word-addressed instance for the wrap-around case.
    logic       r8_valid;
    logic [7:0] r8_target, pps8, mis_addr8, cnt8;
    logic       mis8;
    logic [1:0] state8;

    pc_fetch_unit_if #(.XLEN(8)) fif8 ();

    pc_fetch_unit #(
        .XLEN(8), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h10),
        .PC_STEP(1), .ALIGN_BITS(0), .CNT_W(8)
    ) dut8 (
        .clk(clk), .reset(reset), .stall(1'b0),
        .redirect_valid(r8_valid), .redirect_target(r8_target),
        .trap_valid(1'b0), .halt_req(1'b0), .resume(1'b0),
        .fetch(fif8), .pc_plus_step(pps8), .misaligned(mis8),
        .misaligned_addr(mis_addr8), .state(state8), .fetch_count(cnt8)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted fetch must match the next queued address.
    always @(negedge clk) begin
        if (!reset && fif.fetch_valid && fif.fetch_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got pc %h expected none", fif.pc);
            end else begin
                chk("fetch_pc", fif.pc, exp_q.pop_front());
                $display("fetch pc=%h count=%0d", fif.pc, fetch_count);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
        halt_req = 1'b0; resume = 1'b0; redirect_target = '0;
        fif.fetch_ready = 1'b1;
        r8_valid = 1'b0; r8_target = '0; fif8.fetch_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state, held through the boot edge.
        chk("rst_state", 32'(state), 32'(ST_BOOT));
        chk("rst_pc", fif.pc, 32'h0);
        chk("rst_fv", 32'(fif.fetch_valid), 32'h0);
        chk("rst_cnt", fetch_count, 32'h0);
        chk("rst_mis", 32'(misaligned), 32'h0);
        chk("rst_mis_addr", misaligned_addr, 32'h0);

        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        tick();
        chk("boot_state", 32'(state), 32'(ST_RUN));
        chk("boot_pc", fif.pc, 32'h0);
        chk("boot_fv", 32'(fif.fetch_valid), 32'h1);
        repeat (4) tick();
        chk("seq_pc", fif.pc, 32'h10);
        chk("seq_cnt", fetch_count, 32'd4);

        // Stall holds pc and drops fetch_valid.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", fif.pc, 32'h10);
            chk("stall_fv", 32'(fif.fetch_valid), 32'h0);
        end
        stall = 1'b0;
        exp_q.push_back(32'h10);
        tick();
        chk("unstall_pc", fif.pc, 32'h14);
        chk("pc_plus_step", pc_plus_step, 32'h18);

        // Redirect overrides stall; trap overrides redirect.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        tick();
        chk("redir_stall_pc", fif.pc, 32'h40);
        trap_valid = 1'b1;
        tick();
        chk("trap_pc", fif.pc, 32'h100);
        chk("trap_cnt", fetch_count, 32'd5);

        // Misaligned redirect coinciding with an accepted fetch.
        stall = 1'b0; trap_valid = 1'b0; redirect_target = 32'h42;
        exp_q.push_back(32'h100);
        tick();
        chk("mis_pc", fif.pc, 32'h100);
        chk("mis_pulse", 32'(misaligned), 32'h1);
        chk("mis_addr", misaligned_addr, 32'h42);
        chk("mis_cnt", fetch_count, 32'd6);
        redirect_valid = 1'b0;
        exp_q.push_back(32'h100);
        tick();
        chk("mis_clear", 32'(misaligned), 32'h0);
        chk("mis_addr_hold", misaligned_addr, 32'h42);
        chk("after_mis_pc", fif.pc, 32'h104);

        // Halt: the halting edge still steps pc, then pc is frozen.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h20;
        tick();
        stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b1;
        exp_q.push_back(32'h20);
        tick();
        chk("halt_pc", fif.pc, 32'h24);
        chk("halt_state", 32'(state), 32'(ST_HALT));
        halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halted_pc", fif.pc, 32'h24);
            chk("halted_fv", 32'(fif.fetch_valid), 32'h0);
        end
        halt_req = 1'b1; resume = 1'b1;
        tick();
        chk("halt_resume_both", 32'(state), 32'(ST_HALT));
        halt_req = 1'b0;
        tick();
        chk("resume_state", 32'(state), 32'(ST_RUN));
        resume = 1'b0;
        exp_q.push_back(32'h24);
        tick();
        chk("resume_pc", fif.pc, 32'h28);
        stall = 1'b1;

        // Narrow instance: 0xFF steps to 0x00 without any flag.
        r8_valid = 1'b1; r8_target = 8'hFF;
        tick();
        chk("w8_pc", 32'(fif8.pc), 32'hFF);
        chk("w8_pps", 32'(pps8), 32'h00);
        chk("w8_nomis", 32'(mis8), 32'h0);
        r8_valid = 1'b0; fif8.fetch_ready = 1'b1;
        tick();
        chk("w8_wrap", 32'(fif8.pc), 32'h00);
        chk("w8_cnt", 32'(cnt8), 32'h1);
        fif8.fetch_ready = 1'b0;

        // Asynchronous reset mid-cycle takes effect before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'(ST_BOOT));
        chk("arst_pc", fif.pc, 32'h0);
        chk("arst_cnt", fetch_count, 32'h0);
        chk("arst_mis_addr", misaligned_addr, 32'h0);
        chk("arst_w8_state", 32'(state8), 32'(ST_BOOT));
        #1;
        reset = 1'b0;
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        chk("w8_mis_addr", 32'(mis_addr8), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
